// File: rtl/dec2bin_entry.sv
// ---------------------------------------------------------------------------
// dec2bin_entry
//   Four-digit decimal entry from three pushbuttons. The user edits BCD
//   digits with inc/sel; ENTER converts the digits into a 14-bit binary value
//   (0..9999) by a sequential reverse double-dabble: the 30-bit register
//   {bcd, 14'b0} is shifted right 14 times. After each shift, every BCD field
//   that is >= 8 has 3 subtracted from it.
//
// Parameters
//   DEBOUNCE_BITS : debounce counter width. A button level must stay stable
//                   for 2**DEBOUNCE_BITS clocks before it is accepted.
//
// Ports
//   clk        in   system clock
//   clr        in   synchronous active-high reset
//   btn_inc    in   raw button: increment the digit at the cursor
//   btn_sel    in   raw button: move the cursor one digit left (wraps)
//   btn_enter  in   raw button: start a conversion
//   bcd        out  edit digits {d3,d2,d1,d0}, each 0..9
//   cursor     out  index of the digit being edited
//   busy       out  high while converting (CONV and DONE)
//   bin        out  last converted value, held until the next conversion
//   bin_valid  out  one-cycle pulse when bin updates
// ---------------------------------------------------------------------------
module dec2bin_entry #(
  parameter int DEBOUNCE_BITS = 20
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        btn_inc,
  input  logic        btn_sel,
  input  logic        btn_enter,
  output logic [15:0] bcd,
  output logic [1:0]  cursor,
  output logic        busy,
  output logic [13:0] bin,
  output logic        bin_valid
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int NBTN = 3;  // bit 0 = inc, bit 1 = sel, bit 2 = enter
  localparam logic [DEBOUNCE_BITS-1:0] CNT_MAX = {DEBOUNCE_BITS{1'b1}};

  // One reverse double-dabble iteration: shift right, then every BCD field
  // that is >= 8 has 3 subtracted from it.
  function automatic logic [29:0] dd_step(input logic [29:0] sr_in);
    logic [29:0] t;
    t = sr_in >> 1;
    for (int k = 0; k < 4; k++) begin
      if (t[14 + 4*k +: 4] >= 4'd8) begin
        t[14 + 4*k +: 4] = t[14 + 4*k +: 4] - 4'd3;
      end else begin
        t[14 + 4*k +: 4] = t[14 + 4*k +: 4];
      end
    end
    return t;
  endfunction

  // Increment one BCD digit, wrapping from 9 back to 0.
  function automatic logic [3:0] digit_inc(input logic [3:0] d);
    logic [3:0] r;
    if (d >= 4'd9) begin
      r = 4'd0;
    end else begin
      r = d + 4'd1;
    end
    return r;
  endfunction

  logic [NBTN-1:0]          raw_s;
  logic [NBTN-1:0]          sync1_r;
  logic [NBTN-1:0]          sync2_r;
  logic [NBTN-1:0]          deb_r;
  logic [NBTN-1:0]          deb_prev_r;
  logic [DEBOUNCE_BITS-1:0] cnt_r [NBTN];
  logic [NBTN-1:0]          evt_s;

  state_t       state_r;
  logic [29:0]  sr_r;
  logic [29:0]  sr_next_s;
  logic [3:0]   iter_r;
  logic [15:0]  bcd_r;
  logic [1:0]   cursor_r;
  logic         busy_r;
  logic [13:0]  bin_r;
  logic         bin_valid_r;

  assign raw_s = {btn_enter, btn_sel, btn_inc};

  // Two-flop synchroniser followed by a counter debouncer for each button.
  always_ff @(posedge clk) begin
    if (clr) begin
      sync1_r    <= '0;
      sync2_r    <= '0;
      deb_r      <= '0;
      deb_prev_r <= '0;
      for (int i = 0; i < NBTN; i++) begin
        cnt_r[i] <= '0;
      end
    end else begin
      sync1_r    <= raw_s;
      sync2_r    <= sync1_r;
      deb_prev_r <= deb_r;
      for (int i = 0; i < NBTN; i++) begin
        // The counter only runs while the synced level disagrees with the
        // accepted level; any agreement (a glitch ending) clears it.
        if (sync2_r[i] != deb_r[i]) begin
          if (cnt_r[i] == CNT_MAX) begin
            deb_r[i] <= sync2_r[i];
            cnt_r[i] <= '0;
          end else begin
            cnt_r[i] <= cnt_r[i] + DEBOUNCE_BITS'(1);
          end
        end else begin
          cnt_r[i] <= '0;
        end
      end
    end
  end

  // A debounced rising edge is one event, however long the button is held.
  always_comb begin
    evt_s = deb_r & ~deb_prev_r;
  end

  // Next value of the conversion shift register.
  always_comb begin
    sr_next_s = dd_step(sr_r);
  end

  // Main FSM: digit editing in IDLE, the 14 conversion steps in CONV and a
  // single-cycle DONE. Button events are ignored unless the FSM is in IDLE.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_r     <= ST_IDLE;
      sr_r        <= '0;
      iter_r      <= 4'd0;
      bcd_r       <= 16'd0;
      cursor_r    <= 2'd0;
      busy_r      <= 1'b0;
      bin_r       <= 14'd0;
      bin_valid_r <= 1'b0;
    end else begin
      bin_valid_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (evt_s[2]) begin
            sr_r    <= {bcd_r, 14'd0};
            iter_r  <= 4'd0;
            busy_r  <= 1'b1;
            state_r <= ST_CONV;
          end else if (evt_s[0]) begin
            bcd_r[{cursor_r, 2'b00} +: 4] <= digit_inc(bcd_r[{cursor_r, 2'b00} +: 4]);
          end else if (evt_s[1]) begin
            cursor_r <= cursor_r + 2'd1;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_CONV: begin
          sr_r   <= sr_next_s;
          iter_r <= iter_r + 4'd1;
          // The result is published as DONE is entered, so the bin_valid
          // pulse coincides with the DONE cycle (the last busy cycle).
          if (iter_r == 4'd13) begin
            bin_r       <= sr_next_s[13:0];
            bin_valid_r <= 1'b1;
            state_r     <= ST_DONE;
          end else begin
            state_r <= ST_CONV;
          end
        end
        ST_DONE: begin
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign bcd       = bcd_r;
  assign cursor    = cursor_r;
  assign busy      = busy_r;
  assign bin       = bin_r;
  assign bin_valid = bin_valid_r;

endmodule
